// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller: 8 lines x 32 bytes,
// CPU strobe/ready front end, byte-wide req/ack back end to SDRAM.
module cache_controller #(
  parameter int ADDR_W   = 16,
  parameter int TAG_W    = 8,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [ADDR_W-1:0] add,
  input  logic              wr_rd,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              rdy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);
  localparam int LINES  = 1 << INDEX_W;
  localparam int LINE_B = 1 << OFFSET_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, COMPLETE, RELEASE} state_t;

  state_t                    state;
  logic [7:0]                data_mem [0:LINES*LINE_B-1];
  logic [TAG_W-1:0]          tag_mem  [0:LINES-1];
  logic [LINES-1:0]          valid, dirty;
  logic [TAG_W-1:0]          req_tag;
  logic [INDEX_W-1:0]        req_idx;
  logic [OFFSET_W-1:0]       req_off;
  logic                      req_wr;
  logic [7:0]                req_wdata;
  logic [OFFSET_W-1:0]       cnt;
  logic                      hit, last_ack;

  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_ack = mem_req && mem_ack && (&cnt);

  // Line store and tags carry no reset; only valid/dirty decide residency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        LOOKUP:   if (hit && req_wr) data_mem[{req_idx, req_off}] <= req_wdata;
        COMPLETE: if (req_wr)        data_mem[{req_idx, req_off}] <= req_wdata;
        FILL: begin
          if (mem_req && mem_ack) data_mem[{req_idx, cnt}] <= mem_rdata;
          if (last_ack)           tag_mem[req_idx]         <= req_tag;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid     <= '0;
      dirty     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (cs) begin
          req_tag   <= add[ADDR_W-1 -: TAG_W];
          req_idx   <= add[OFFSET_W +: INDEX_W];
          req_off   <= add[OFFSET_W-1:0];
          req_wr    <= wr_rd;
          req_wdata <= cpu_wdata;
          rdy       <= 1'b0;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          cnt <= '0;
          if (hit) begin
            if (req_wr) dirty[req_idx] <= 1'b1;
            else        cpu_rdata      <= data_mem[{req_idx, req_off}];
            state <= RELEASE;
          end else if (valid[req_idx] && dirty[req_idx]) begin
            state <= WRITEBACK;
          end else begin
            state <= FILL;
          end
        end
        // req is low for one cycle after every ack, then the next byte goes out
        WRITEBACK: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_mem[req_idx], req_idx, cnt};
            mem_wdata <= data_mem[{req_idx, cnt}];
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (&cnt) begin
              cnt   <= '0;
              state <= FILL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_idx, cnt};
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (&cnt) begin
              valid[req_idx] <= 1'b1;
              dirty[req_idx] <= 1'b0;
              state          <= COMPLETE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMPLETE: begin
          if (req_wr) dirty[req_idx] <= 1'b1;
          else        cpu_rdata      <= data_mem[{req_idx, req_off}];
          state <= RELEASE;
        end
        RELEASE: if (!cs) begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller: behavioural cache/SDRAM model
// predicts memory traffic and read data; monitors check on ack and on rdy rise.
module tb_cache_controller;
  logic        clk, rst, cs, wr_rd, rdy, mem_req, mem_we, mem_ack;
  logic [15:0] add, mem_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;

  cache_controller dut (
    .clk(clk), .rst(rst), .cs(cs), .add(add), .wr_rd(wr_rd),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .rdy(rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct { bit we; logic [15:0] addr; logic [7:0] data; } mem_op_t;
  typedef struct { logic [7:0] rdata; int total; } rsp_t;

  mem_op_t    exp_mem [$];
  rsp_t       exp_rsp [$];
  int         checks = 0, errors = 0;
  int         exp_total = 0, obs_total = 0;
  bit         rand_ack = 0;
  logic [7:0] sdram [0:65535];

  // reference model: cache contents as plain arrays plus its own view of SDRAM
  logic [7:0] rmem [0:65535];
  logic [7:0] rl   [0:7][0:31];
  logic [7:0] rtag [0:7];
  bit         rv [0:7], rd [0:7];
  logic [7:0] last_rd = 0;

  logic cs_q;
  always @(posedge clk) cs_q <= cs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic finish_tb();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 8; i++) begin rv[i] = 0; rd[i] = 0; end
    last_rd = 0;
    exp_mem.delete();
    exp_rsp.delete();
    exp_total = obs_total;
  endtask

  task automatic ref_access(input logic [15:0] a, input logic w, input logic [7:0] d, output bit hit);
    logic [7:0]  t;
    logic [2:0]  i;
    logic [4:0]  o;
    logic [15:0] ad;
    t = a[15:8]; i = a[7:5]; o = a[4:0];
    hit = rv[i] && rtag[i] == t;
    if (!hit) begin
      if (rv[i] && rd[i])
        for (int b = 0; b < 32; b++) begin
          ad = {rtag[i], i, 5'(b)};
          exp_mem.push_back('{1'b1, ad, rl[i][b]});
          rmem[ad] = rl[i][b];
          exp_total++;
        end
      for (int b = 0; b < 32; b++) begin
        ad = {t, i, 5'(b)};
        exp_mem.push_back('{1'b0, ad, 8'h00});
        rl[i][b] = rmem[ad];
        exp_total++;
      end
      rtag[i] = t; rv[i] = 1; rd[i] = 0;
    end
    if (w) begin rl[i][o] = d; rd[i] = 1; end
    else last_rd = rl[i][o];
    exp_rsp.push_back('{last_rd, exp_total});
  endtask

  // SDRAM model: acks after a delay, checks each handshake against the expected stream
  initial begin
    logic [15:0] lat_a;
    logic        lat_we;
    logic [7:0]  lat_wd;
    bit          in_req;
    int          wait_c;
    mem_op_t     e;
    mem_ack = 0; mem_rdata = 0; in_req = 0; wait_c = 2;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 0;
        chk("req_drop_after_ack", mem_req, 0);
      end else if (rst) begin
        in_req = 0;
      end else if (mem_req) begin
        if (!in_req) begin
          in_req = 1; lat_a = mem_addr; lat_we = mem_we; lat_wd = mem_wdata;
        end else begin
          chk("req_stable", {mem_addr, mem_we, mem_wdata}, {lat_a, lat_we, lat_wd});
        end
        if (wait_c == 0) begin
          if (exp_mem.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_op: got addr %0h we %0b expected none", mem_addr, mem_we);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) chk("mem_wdata", mem_wdata, e.data);
          end
          if (mem_we) sdram[mem_addr] = mem_wdata;
          else        mem_rdata = sdram[mem_addr];
          mem_ack = 1;
          obs_total++;
          in_req = 0;
          wait_c = rand_ack ? int'($urandom_range(7, 0)) : 2;
        end else begin
          wait_c--;
        end
      end
    end
  end

  // response monitor: each rdy rise completes exactly one request
  initial begin
    bit   prev_rdy;
    rsp_t r;
    prev_rdy = 1;
    forever begin
      @(negedge clk);
      if (!rst && rdy && !prev_rdy) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rdy: got rdy rise expected none");
        end else begin
          r = exp_rsp.pop_front();
          chk("cpu_rdata", cpu_rdata, r.rdata);
          chk("mem_txn_count", obs_total, r.total);
          chk("cs_low_before_rdy", cs_q, 0);
        end
      end
      prev_rdy = rdy;
    end
  end

  task automatic do_req(input logic [15:0] a, input logic w, input logic [7:0] d, input int hold);
    bit hit, done;
    int n;
    for (int k = 0; k < 100 && !rdy; k++) begin @(posedge clk); #1; end
    cs = 1; add = a; wr_rd = w; cpu_wdata = d;
    ref_access(a, w, d, hit);
    n = 0; done = 0;
    while (!done && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin  // scramble inputs: must be ignored while busy
        add = 16'($urandom); wr_rd = 1'($urandom); cpu_wdata = 8'($urandom);
      end
      if (n >= hold) cs = 0;
      if (rdy) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no rdy after %0d cycles expected rdy for addr %0h", n, a);
      finish_tb();
    end
    if (hit && hold == 1) chk("hit_latency", n, 3);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] t;
    int target;
    for (int a = 0; a < 65536; a++) begin
      sdram[a] = 8'(a) ^ 8'(a >> 8);
      rmem[a]  = 8'(a) ^ 8'(a >> 8);
    end
    rst = 1; cs = 0; add = 0; wr_rd = 0; cpu_wdata = 0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", rdy, 1);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 0;
    @(posedge clk); #1;

    do_req(16'h1234, 0, 8'h00, 200);         // cold read, cs held past the fill
    chk("rd_1234_cold", cpu_rdata, 8'h26);
    do_req(16'h1234, 1, 8'hAA, 1);           // write hit
    do_req(16'h1234, 0, 8'h00, 1);           // read hit
    chk("rd_1234_hit", cpu_rdata, 8'hAA);
    do_req(16'hFF34, 0, 8'h00, 4);           // dirty miss: writeback then fill
    chk("rd_ff34", cpu_rdata, 8'hCB);
    do_req(16'h1234, 0, 8'h00, 4);           // clean miss, sees written-back 0xAA
    chk("rd_1234_back", cpu_rdata, 8'hAA);
    do_req(16'h5501, 1, 8'h77, 4);           // write miss, clean index 0
    do_req(16'h5501, 0, 8'h00, 1);
    chk("rd_5501", cpu_rdata, 8'h77);

    // reset during the 10th ack of a fill
    target = obs_total + 10;
    cs = 1; add = 16'h3344; wr_rd = 0;
    begin bit h; ref_access(16'h3344, 1'b0, 8'h00, h); end
    @(posedge clk); #1;
    cs = 0;
    for (int k = 0; k < 1000 && obs_total < target; k++) begin @(posedge clk); #2; end
    chk("rst_ack_reached", obs_total, target);
    rst = 1;
    @(posedge clk); #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_rdy", rdy, 1);
    @(posedge clk); #1;
    ref_reset();
    rst = 0;
    @(posedge clk); #1;
    do_req(16'h3344, 0, 8'h00, 2);           // must refetch the whole line
    chk("rd_3344", cpu_rdata, 8'h77);

    rand_ack = 1;
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(3, 0))
        0: t = 8'h12;
        1: t = 8'h55;
        2: t = 8'hA0;
        default: t = 8'($urandom);
      endcase
      do_req({t, 3'($urandom_range(7, 0)), 5'($urandom_range(31, 0))},
             1'($urandom_range(1, 0)), 8'($urandom), 4);
    end

    repeat (5) @(posedge clk);
    chk("exp_rsp_drained", exp_rsp.size(), 0);
    chk("exp_mem_drained", exp_mem.size(), 0);
    finish_tb();
  end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller. It is the responder to the CPU-side cs/add/wr_rd/dout/din/rdy request interface.
- It holds tag, valid and dirty state plus a 256-byte line store.
- Misses are serviced over a byte-wide request/acknowledge port to the SDRAM model.
- It sits between the CPU test driver and the SDRAM model and resolves read hit, write hit, clean miss and dirty miss.

Parameters:
- ADDR_W, 16, address width.
- TAG_W, 8, tag bits, add[15:8].
- INDEX_W, 3, line index, add[7:5]; 8 lines.
- OFFSET_W, 5, byte offset, add[4:0]; 32-byte lines. TAG_W+INDEX_W+OFFSET_W must equal ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  CPU request strobe; held high for several cycles per request.
- add  in  16  CPU byte address.
- wr_rd  in  1  1 = write, 0 = read.
- cpu_wdata  in  8  CPU write data (driven by the CPU's dout).
- cpu_rdata  out  8  read data to the CPU (the CPU's din).
- rdy  out  1  1 = idle, able to accept a request, previous result complete.
- mem_req  out  1  SDRAM byte request.
- mem_we  out  1  1 = SDRAM write.
- mem_addr  out  16  SDRAM byte address.
- mem_wdata  out  8  SDRAM write data.
- mem_rdata  in  8  SDRAM read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse for the current mem_req.

Behaviour:
- Reset:
  - rdy=1, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All valid and dirty bits cleared; state IDLE.
  - Tag and data arrays are not reset.
  - Reset mid-operation aborts immediately: mem_req drops the next edge and no partial line is marked valid.
- States: IDLE, LOOKUP, WRITEBACK, FILL, COMPLETE, RELEASE.
- IDLE:
  - rdy=1.
  - On cs=1 sampled: latch add, wr_rd, cpu_wdata; rdy<=0 on that edge; go to LOOKUP.
  - cs=0: stay in IDLE.
- LOOKUP (one cycle). Hit means valid[idx] and tag[idx]==add[15:8].
  - Read hit: cpu_rdata<=line[idx][off]; go to RELEASE.
  - Write hit: line[idx][off]<=wdata, dirty[idx]<=1; go to RELEASE.
  - Miss with valid and dirty set: go to WRITEBACK.
  - Otherwise: go to FILL.
- WRITEBACK:
  - 32 sequential SDRAM writes, offsets 0..31.
  - mem_addr={tag[idx],idx,cnt}, mem_we=1, mem_wdata=line[idx][cnt].
  - cnt advances on mem_ack; after ack of offset 31, go to FILL.
- FILL:
  - 32 sequential SDRAM reads.
  - mem_addr={latched tag,idx,cnt}, mem_we=0.
  - On each mem_ack: line[idx][cnt]<=mem_rdata.
  - After offset 31: tag[idx]<=latched tag, valid<=1, dirty<=0; go to COMPLETE.
- COMPLETE (one cycle): perform the latched access on the now-resident line, exactly as read hit / write hit (write sets dirty=1); go to RELEASE.
- RELEASE: wait until cs sampled 0, then rdy<=1 and go to IDLE. This guarantees one request per cs assertion.
- Memory handshake:
  - mem_req rises with mem_addr/mem_we/mem_wdata stable, and all are held until mem_ack.
  - mem_req drops for at least one cycle after each ack, then the next byte is requested.
  - mem_ack while mem_req=0 is ignored. Arbitrary ack delay is supported.
- Counter: 5-bit cnt, cleared on entry to WRITEBACK and to FILL; terminal at 31, no wrap into the next line.
- cpu_rdata holds its value until the next read completes. It is valid when rdy rises after a read.
- Writes never change cpu_rdata.
- Changes to cs, add or wr_rd while rdy=0 are ignored, apart from the RELEASE cs check.
- Latency, cs edge to rdy, with cs already low:
  - Read/write hit: rdy high 3 edges after cs is sampled.
  - Clean miss: adds 32 handshakes.
  - Dirty miss: adds 64 handshakes.
  - If cs is still high, rdy waits for cs=0.

Test Plan:
SDRAM model: mem[a]=a[7:0]^a[15:8]; ack 2 cycles after req.
- Read 0x1234, cold cache -> 32 reads at 0x1220..0x123F, no writes; cpu_rdata=0x26; rdy returns high only after cs low; line 1 valid, clean.
- Write 0xAA to 0x1234 -> zero mem_req; line 1 dirty.
  - Then read 0x1234 -> zero mem_req; cpu_rdata=0xAA.
- Read 0xFF34 (same index, tag 0xFF) -> 32 writes to 0x1220..0x123F; byte 0x1234=0xAA, rest unchanged.
  - Then 32 reads at 0xFF20..0xFF3F; cpu_rdata=0xCB; dirty=0.
- Write miss 0x5501 (data 0x77) to clean index 0 -> fill 0x5500..0x551F, no writeback.
  - Then read 0x5501 -> 0x77, no memory traffic.
- Assert rst at the 10th ack of a fill -> mem_req=0 next edge, rdy=1.
  - Re-read of the same address misses and refetches all 32 bytes.
- Ack delay randomized 0..7 cycles, cs held 4 cycles -> mem_addr/mem_wdata stable under mem_req; exactly one transaction per cs assertion.
